// File: rtl/hht_control_if.sv
// Bus bundle between the HHT controller and its surroundings: CPU address
// forwarding, register-file read ports, two memory read ports and the
// row-result strobe.
interface hht_control_if;
    logic        RD;
    logic [31:0] csize;
    logic [31:0] cpu_addr;
    logic [31:0] base_dat_a;
    logic [31:0] base_dat_b;
    logic [31:0] dataIn1;
    logic [31:0] dataIn2;
    logic [31:0] addr1;
    logic [31:0] addr2;
    logic [4:0]  regaddr1;
    logic [4:0]  regaddr2;
    logic        hht;
    logic [4:0]  rdata;
    logic [4:0]  adata;

    // Controller side.
    modport master (
        input  RD, csize, cpu_addr, base_dat_a, base_dat_b, dataIn1, dataIn2,
        output addr1, addr2, regaddr1, regaddr2, hht, rdata, adata
    );

    // CPU / memory / register-file side.
    modport slave (
        output RD, csize, cpu_addr, base_dat_a, base_dat_b, dataIn1, dataIn2,
        input  addr1, addr2, regaddr1, regaddr2, hht, rdata, adata
    );
endinterface

// File: rtl/hht_control.sv
// Hardware-helper-thread controller for CSR SpMV. Walks the row-pointer,
// column-index and value arrays over two combinational read ports, forms one
// 32-bit dot product per row and strobes hht with the row index and its
// (saturated) non-zero count. When inactive the CPU load address is forwarded.
module hht_control #(
    parameter int N_ROWS  = 16,
    parameter int REG_COL = 6,
    parameter int REG_VEC = 8,
    parameter int REG_ROW = 15,
    parameter int REG_VAL = 9
) (
    input  logic          clk,
    input  logic          rst,
    hht_control_if.master bus
);

    localparam logic [4:0]  REG_COL_IDX = 5'(REG_COL);
    localparam logic [4:0]  REG_VEC_IDX = 5'(REG_VEC);
    localparam logic [4:0]  REG_ROW_IDX = 5'(REG_ROW);
    localparam logic [4:0]  REG_VAL_IDX = 5'(REG_VAL);
    localparam logic [31:0] LAST_ROW    = 32'(N_ROWS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_BASE0, S_BASE1, S_RP0, S_RP1,
        S_EL_A, S_EL_B, S_ROWDONE, S_DONE
    } state_t;

    state_t      state_q;
    logic [31:0] col_base_q, vec_base_q, row_base_q, val_base_q;
    logic [31:0] start_q, end_q, k_q, cnt_q, processed_q, row_q;
    logic [31:0] col_q, val_q, row_sum_q;
    logic        hht_q;
    logic [4:0]  rdata_q, adata_q, regaddr1_q, regaddr2_q;

    logic [31:0] k_d, cnt_d, processed_d, row_sum_d;
    logic [31:0] addr1, addr2;

    // Non-zero count reported with hht saturates at 31 to fit in 5 bits.
    function automatic logic [4:0] sat5(input logic [31:0] v);
        return (v > 32'd31) ? 5'd31 : v[4:0];
    endfunction

    // Element-step arithmetic and the state-dependent port addresses.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        k_d         = k_q + 32'd1;
        cnt_d       = cnt_q + 32'd1;
        processed_d = processed_q + 32'd1;
        row_sum_d   = row_sum_q + val_q * bus.dataIn2;
        addr1       = col_base_q + k_q;
        addr2       = val_base_q + k_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                addr1 = bus.cpu_addr;
                addr2 = bus.cpu_addr;
            end
            S_RP0:   addr1 = row_base_q + row_q;
            S_RP1:   addr1 = row_base_q + row_q + 32'd1;
            S_EL_B:  addr2 = vec_base_q + col_q;
            default: ;
        endcase
    end

    // Controller FSM: all state, datapath registers and registered outputs.
    // While RD is low every register holds, which also freezes the addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q     <= S_IDLE;
            col_base_q  <= '0;
            vec_base_q  <= '0;
            row_base_q  <= '0;
            val_base_q  <= '0;
            start_q     <= '0;
            end_q       <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            processed_q <= '0;
            row_q       <= '0;
            col_q       <= '0;
            val_q       <= '0;
            row_sum_q   <= '0;
            hht_q       <= 1'b0;
            rdata_q     <= '0;
            adata_q     <= '0;
            regaddr1_q  <= REG_COL_IDX;
            regaddr2_q  <= REG_ROW_IDX;
        end else if (bus.RD) begin
            case (state_q)
                S_IDLE: state_q <= S_BASE0;
                S_BASE0: begin
                    col_base_q <= bus.base_dat_a;
                    row_base_q <= bus.base_dat_b;
                    regaddr1_q <= REG_VEC_IDX;
                    regaddr2_q <= REG_VAL_IDX;
                    state_q    <= S_BASE1;
                end
                S_BASE1: begin
                    vec_base_q <= bus.base_dat_a;
                    val_base_q <= bus.base_dat_b;
                    regaddr1_q <= REG_COL_IDX;
                    regaddr2_q <= REG_ROW_IDX;
                    state_q    <= S_RP0;
                end
                S_RP0: begin
                    start_q <= bus.dataIn1;
                    state_q <= S_RP1;
                end
                S_RP1: begin
                    end_q     <= bus.dataIn1;
                    k_q       <= start_q;
                    row_sum_q <= '0;
                    cnt_q     <= '0;
                    if (start_q < bus.dataIn1) begin
                        state_q <= S_EL_A;
                    end else begin
                        hht_q   <= 1'b1;
                        rdata_q <= row_q[4:0];
                        adata_q <= '0;
                        state_q <= S_ROWDONE;
                    end
                end
                S_EL_A: begin
                    col_q   <= bus.dataIn1;
                    val_q   <= bus.dataIn2;
                    state_q <= S_EL_B;
                end
                S_EL_B: begin
                    row_sum_q   <= row_sum_d;
                    k_q         <= k_d;
                    cnt_q       <= cnt_d;
                    processed_q <= processed_d;
                    if (k_d < end_q && processed_d < bus.csize) begin
                        state_q <= S_EL_A;
                    end else begin
                        hht_q   <= 1'b1;
                        rdata_q <= row_q[4:0];
                        adata_q <= sat5(cnt_d);
                        state_q <= S_ROWDONE;
                    end
                end
                S_ROWDONE: begin
                    hht_q <= 1'b0;
                    if (processed_q >= bus.csize || row_q == LAST_ROW) begin
                        state_q <= S_DONE;
                    end else begin
                        row_q   <= row_q + 32'd1;
                        state_q <= S_RP0;
                    end
                end
                default: ;  // S_DONE: parked until reset
            endcase
        end
    end

    assign bus.addr1    = addr1;
    assign bus.addr2    = addr2;
    assign bus.regaddr1 = regaddr1_q;
    assign bus.regaddr2 = regaddr2_q;
    assign bus.hht      = hht_q;
    assign bus.rdata    = rdata_q;
    assign bus.adata    = adata_q;

endmodule

// File: tb/tb_hht_control.sv
// Self-checking bench for hht_control: memory and register file modelled as
// arrays, expected row results computed from the CSR definition of SpMV.
module tb_hht_control;
    localparam int N_ROWS = 16;
    localparam logic [31:0] COL_BASE = 32'd3200;
    localparam logic [31:0] VEC_BASE = 32'd2;
    localparam logic [31:0] ROW_BASE = 32'd34300;
    localparam logic [31:0] VAL_BASE = 32'd90;

    logic clk = 1'b0;
    logic rst;
    hht_control_if bus ();

    hht_control #(.N_ROWS(N_ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Backing storage seen through the two read ports.
    logic [31:0] vec_m    [16];
    logic [31:0] rowptr_m [N_ROWS + 1];
    logic [31:0] col_m    [256];
    logic [31:0] val_m    [256];
    int          mem_gen = 0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_row [$];
    logic [31:0] exp_cnt [$];
    logic [31:0] exp_sum [$];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a >= ROW_BASE && a <= ROW_BASE + 32'(N_ROWS)) return rowptr_m[int'(a - ROW_BASE)];
        if (a >= COL_BASE && a <  COL_BASE + 32'd256)     return col_m[int'(a - COL_BASE)];
        if (a >= VAL_BASE && a <  VAL_BASE + 32'd256)     return val_m[int'(a - VAL_BASE)];
        if (a >= VEC_BASE && a <  VEC_BASE + 32'd16)      return vec_m[int'(a - VEC_BASE)];
        return 32'd0;
    endfunction

    function automatic logic [31:0] reg_read(input logic [4:0] idx);
        case (idx)
            5'd6:    return COL_BASE;
            5'd8:    return VEC_BASE;
            5'd15:   return ROW_BASE;
            5'd9:    return VAL_BASE;
            default: return 32'hdead_0000 | 32'(idx);
        endcase
    endfunction

    // Combinational memory and register-file responses.
    always @(bus.addr1 or bus.addr2 or bus.regaddr1 or bus.regaddr2 or mem_gen) begin
        bus.dataIn1    = mem_read(bus.addr1);
        bus.dataIn2    = mem_read(bus.addr2);
        bus.base_dat_a = reg_read(bus.regaddr1);
        bus.base_dat_b = reg_read(bus.regaddr2);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: y[r] = sum over k in [rowptr[r], rowptr[r+1]) of val[k]*x[col[k]],
    // stopping once csize non-zeros have been consumed in total.
    function automatic void build_expected(input logic [31:0] cs);
        logic [31:0] processed, sum, cnt;
        exp_row.delete();
        exp_cnt.delete();
        exp_sum.delete();
        processed = 0;
        for (int r = 0; r < N_ROWS; r++) begin
            int k;
            k   = int'(rowptr_m[r]);
            sum = 0;
            cnt = 0;
            if (k < int'(rowptr_m[r + 1])) begin
                do begin
                    sum = sum + val_m[k] * vec_m[col_m[k][3:0]];
                    k++;
                    cnt++;
                    processed++;
                end while (k < int'(rowptr_m[r + 1]) && processed < cs);
            end
            exp_row.push_back(32'(r));
            exp_cnt.push_back(cnt);
            exp_sum.push_back(sum);
            if (processed >= cs) break;
        end
    endfunction

    task automatic reset_dut();
        rst          = 1'b1;
        bus.RD       = 1'b0;
        bus.cpu_addr = 32'd126;
        repeat (2) @(negedge clk);
        check("rst_hht",      32'(bus.hht),      32'd0);
        check("rst_rdata",    32'(bus.rdata),    32'd0);
        check("rst_adata",    32'(bus.adata),    32'd0);
        check("rst_regaddr1", 32'(bus.regaddr1), 32'd6);
        check("rst_regaddr2", 32'(bus.regaddr2), 32'd15);
        check("rst_addr1",    bus.addr1,         32'd126);
        rst = 1'b0;
    endtask

    task automatic run_matrix(input logic [31:0] cs, input bit directed, input int stall_at);
        int          cyc, prev;
        logic [31:0] snap1, snap2, er, ec, es, ca;
        build_expected(cs);
        bus.csize = cs;
        reset_dut();
        cyc  = 0;
        prev = 2;
        @(negedge clk);
        bus.RD = 1'b1;
        while (exp_row.size() > 0 && cyc < 4000) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (directed) begin
                case (cyc)
                    1: begin
                        check("base0_regaddr1", 32'(bus.regaddr1), 32'd6);
                        check("base0_regaddr2", 32'(bus.regaddr2), 32'd15);
                    end
                    2: begin
                        check("base1_regaddr1", 32'(bus.regaddr1), 32'd8);
                        check("base1_regaddr2", 32'(bus.regaddr2), 32'd9);
                    end
                    3: check("rp0_addr1",  bus.addr1, 32'd34300);
                    4: check("rp1_addr1",  bus.addr1, 32'd34301);
                    5: begin
                        check("ela_addr1", bus.addr1, 32'd3200);
                        check("ela_addr2", bus.addr2, 32'd90);
                    end
                    6: check("elb_addr2",  bus.addr2, 32'd2);
                    default: ;
                endcase
            end
            if (stall_at > 0) begin
                if (cyc == stall_at) begin
                    bus.RD = 1'b0;
                    snap1  = bus.addr1;
                    snap2  = bus.addr2;
                end else if (cyc > stall_at && cyc <= stall_at + 10) begin
                    check("stall_addr1", bus.addr1, snap1);
                    check("stall_addr2", bus.addr2, snap2);
                    if (cyc == stall_at + 10) bus.RD = 1'b1;
                end
            end
            // A strobe is consumed on the edge where RD is high.
            if (bus.hht && bus.RD) begin
                er = exp_row.pop_front();
                ec = exp_cnt.pop_front();
                es = exp_sum.pop_front();
                check("rdata",   32'(bus.rdata), er);
                check("adata",   32'(bus.adata), (ec > 32'd31) ? 32'd31 : ec);
                check("row_sum", dut.row_sum_q,  es);
                if (stall_at == 0) check("row_latency", 32'(cyc), 32'(prev + 3 + 2 * int'(ec)));
                prev = cyc;
            end
        end
        check("rows_outstanding", 32'(exp_row.size()), 32'd0);
        // Parked in DONE: no further strobes, CPU address forwarded.
        for (int i = 0; i < 3; i++) begin
            ca           = $urandom;
            bus.cpu_addr = ca;
            @(posedge clk);
            @(negedge clk);
            check("done_hht",   32'(bus.hht), 32'd0);
            check("done_addr1", bus.addr1,    ca);
            check("done_addr2", bus.addr2,    ca);
        end
    endtask

    task automatic load_setup_a();
        logic [31:0] x0 [16] = '{61, 44, 48, 91, 82, 74, 67, 45, 82, 53, 7, 38, 19, 67, 69, 83};
        logic [31:0] c0 [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 8, 9, 10, 11, 12};
        for (int i = 0; i < 16; i++) vec_m[i] = x0[i];
        for (int i = 0; i < 256; i++) begin
            col_m[i] = (i < 14) ? c0[i] : 32'($urandom_range(0, 15));
            val_m[i] = $urandom;
        end
        rowptr_m[0] = 0;
        rowptr_m[1] = 14;
        for (int r = 1; r < N_ROWS; r++) begin
            int nnz;
            nnz = (r == 3) ? 0 : (r == 5) ? 35 : $urandom_range(1, 10);
            rowptr_m[r + 1] = rowptr_m[r] + 32'(nnz);
        end
        mem_gen++;
    endtask

    task automatic load_setup_b();
        for (int i = 0; i < 256; i++) begin
            col_m[i] = 32'($urandom_range(0, 15));
            val_m[i] = $urandom;
        end
        rowptr_m[0] = 0;
        for (int r = 1; r < N_ROWS; r++) rowptr_m[r] = 32'(r * 13 + $urandom_range(0, 8));
        rowptr_m[N_ROWS] = 216;
        mem_gen++;
    endtask

    initial begin
        rst          = 1'b1;
        bus.RD       = 1'b0;
        bus.csize    = 0;
        bus.cpu_addr = 32'd126;

        // Directed first row, an empty row and a row wider than 31 non-zeros.
        load_setup_a();
        run_matrix(32'd1000, 1'b1, 0);

        // Full 16-row matrix with 216 non-zeros under a 230 cap.
        load_setup_b();
        run_matrix(32'd230, 1'b0, 0);
        // Cap cuts the first row after 5 non-zeros.
        run_matrix(32'd5, 1'b0, 0);
        // Cap lands exactly on a row boundary.
        run_matrix(rowptr_m[2], 1'b0, 0);
        // Ten-cycle stall mid-matrix must not change any result.
        run_matrix(32'd230, 1'b0, 40);

        // Reset asserted in the middle of a row.
        reset_dut();
        bus.csize = 32'd1000;
        @(negedge clk);
        bus.RD = 1'b1;
        repeat (20) @(negedge clk);
        bus.cpu_addr = 32'd126;
        rst          = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_hht",   32'(bus.hht), 32'd0);
        check("midrst_addr1", bus.addr1,    32'd126);
        check("midrst_addr2", bus.addr2,    32'd126);
        rst    = 1'b0;
        bus.RD = 1'b0;
        @(negedge clk);
        check("idle_addr1", bus.addr1, 32'd126);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
